// File: rtl/enemy_hit_manager_if.sv
// Interface bundle between the stage/collision logic and enemy_hit_manager.
// Carries the spawn controls, the hit request handshake, the kill event
// handshake and the status outputs (alive vector, score, clear flags).
// The slave modport is the enemy_hit_manager view; master is the driver side.
interface enemy_hit_manager_if #(
    parameter int ENEMY_COUNT = 23,
    parameter int SCORE_W     = 16
);
    // Spawn controls
    logic [ENEMY_COUNT-1:0] enemy_alive_in;
    logic                   reset_fly;
    logic                   reset_spider;
    logic                   reset_mosquito;

    // Hit request handshake
    logic                   hit_valid;
    logic [4:0]             hit_idx;
    logic                   hit_ready;

    // Kill event handshake
    logic                   kill_valid;
    logic [4:0]             kill_idx;
    logic [1:0]             kill_type;
    logic                   kill_ready;

    // Status
    logic [ENEMY_COUNT-1:0] enemy_alive_out;
    logic [SCORE_W-1:0]     score;
    logic [2:0]             group_clear;
    logic                   all_clear;

    modport slave (
        input  enemy_alive_in, reset_fly, reset_spider, reset_mosquito,
        input  hit_valid, hit_idx, kill_ready,
        output hit_ready, kill_valid, kill_idx, kill_type,
        output enemy_alive_out, score, group_clear, all_clear
    );

    modport master (
        output enemy_alive_in, reset_fly, reset_spider, reset_mosquito,
        output hit_valid, hit_idx, kill_ready,
        input  hit_ready, kill_valid, kill_idx, kill_type,
        input  enemy_alive_out, score, group_clear, all_clear
    );
endinterface

// File: rtl/enemy_hit_manager.sv
// enemy_hit_manager: per-enemy liveness and hit points.
// Group spawn strobes load alive bits, accepted hits wear down hit points,
// kills are reported through a single-entry handshaked event register and
// add to a saturating score. Group-clear pulses and an all-clear flag
// summarise the alive vector.
// Optional feature macro: ENEMY_HP_EN -- when defined, spiders take 2 hits
// and mosquitoes 3; when undefined, every hit on a live enemy kills it.
module enemy_hit_manager #(
    parameter int ENEMY_COUNT = 23,
    parameter int FLY_LAST    = 16,
    parameter int SPIDER_LAST = 20,
    parameter int SCORE_W     = 16
) (
    input  logic               clk25,
    input  logic               global_reset_n,
    enemy_hit_manager_if.slave bus
);

    localparam logic [5:0]         COUNT_W6  = 6'(ENEMY_COUNT);
    localparam int                 SUM_W     = SCORE_W + 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ENEMY_COUNT-1:0] alive_q, alive_d;
    logic                   kill_valid_q, kill_valid_d;
    logic [4:0]             kill_idx_q, kill_idx_d;
    logic [1:0]             kill_type_q, kill_type_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [2:0]             group_clear_q, group_clear_d;
    logic                   all_clear_q;

    // Per-slot group membership and this-cycle spawn request
    logic [ENEMY_COUNT-1:0] fly_mask;
    logic [ENEMY_COUNT-1:0] spider_mask;
    logic [ENEMY_COUNT-1:0] mosq_mask;
    logic [ENEMY_COUNT-1:0] spawn_vec;

    // Hit decode
    logic       hit_ready_w;
    logic       hit_fire;
    logic       idx_ok;
    logic [4:0] hit_sel;
    logic       hit_effective;
    logic       kill_now;
    logic [1:0] hit_type;
    logic [6:0] points;

`ifdef ENEMY_HP_EN
    logic [2*ENEMY_COUNT-1:0] hp_flat;
    logic [1:0]               hp_cur;
    logic                     dec_now;
`endif

    // A hit is only refused while an untaken kill event is still parked;
    // during reset nothing is accepted.
    assign hit_ready_w = global_reset_n & ~(kill_valid_q & ~bus.kill_ready);
    assign hit_fire    = bus.hit_valid & hit_ready_w;

    // Out-of-range indices are steered to slot 0 so no array read goes past
    // the end; idx_ok then masks the result.
    assign idx_ok  = ({1'b0, bus.hit_idx} < COUNT_W6);
    assign hit_sel = idx_ok ? bus.hit_idx : 5'd0;

    // A spawn on the target's group overrides the hit in the same cycle.
    assign hit_effective = hit_fire & idx_ok & alive_q[hit_sel] & ~spawn_vec[hit_sel];

`ifdef ENEMY_HP_EN
    assign hp_cur   = hp_flat[{hit_sel, 1'b0} +: 2];
    assign kill_now = hit_effective & (hp_cur <= 2'd1);
    assign dec_now  = hit_effective & (hp_cur > 2'd1);
`else
    assign kill_now = hit_effective;
`endif

    // ------------------------------------------------------------------
    // Per-slot logic
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ENEMY_COUNT; gi++) begin : g_slot
            localparam bit IS_FLY    = (gi <= FLY_LAST);
            localparam bit IS_SPIDER = (gi > FLY_LAST) && (gi <= SPIDER_LAST);
            localparam bit IS_MOSQ   = (gi > SPIDER_LAST);

            logic hit_this;

            assign fly_mask[gi]    = IS_FLY;
            assign spider_mask[gi] = IS_SPIDER;
            assign mosq_mask[gi]   = IS_MOSQ;
            assign spawn_vec[gi]   = (IS_FLY    & bus.reset_fly)
                                   | (IS_SPIDER & bus.reset_spider)
                                   | (IS_MOSQ   & bus.reset_mosquito);

            assign hit_this = (hit_sel == 5'(gi));

            // Spawn loads the slot; otherwise a killing hit clears it.
            assign alive_d[gi] = spawn_vec[gi] ? bus.enemy_alive_in[gi]
                               : ((kill_now & hit_this) ? 1'b0 : alive_q[gi]);

`ifdef ENEMY_HP_EN
            localparam logic [1:0] HP_FULL = IS_FLY ? 2'd1 : (IS_SPIDER ? 2'd2 : 2'd3);

            logic [1:0] hp_q;

            // Hit points: refilled on spawn, decremented by non-fatal hits.
            always_ff @(posedge clk25 or negedge global_reset_n) begin
                if (!global_reset_n) begin
                    hp_q <= 2'd0;
                end else if (spawn_vec[gi]) begin
                    hp_q <= HP_FULL;
                end else if (dec_now && hit_this) begin
                    hp_q <= hp_q - 2'd1;
                end
            end

            assign hp_flat[2*gi +: 2] = hp_q;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Kill event, score and clear detection
    // ------------------------------------------------------------------
    assign hit_type = fly_mask[hit_sel]    ? 2'd0 :
                      spider_mask[hit_sel] ? 2'd1 : 2'd2;

    // Kill value table: fly 10, spider 30, mosquito 50.
    always_comb begin
        points = 7'd50;
        case (hit_type)
            2'd0:    points = 7'd10;
            2'd1:    points = 7'd30;
            default: points = 7'd50;
        endcase
    end

    // Next state for the single-entry kill register; a new kill may replace
    // an event that is being taken this same cycle.
    always_comb begin
        kill_valid_d = kill_valid_q;
        kill_idx_d   = kill_idx_q;
        kill_type_d  = kill_type_q;
        if (kill_now) begin
            kill_valid_d = 1'b1;
            kill_idx_d   = hit_sel;
            kill_type_d  = hit_type;
        end else if (bus.kill_ready) begin
            kill_valid_d = 1'b0;
        end
    end

    // Saturating score accumulation on each kill.
    always_comb begin
        logic [SUM_W-1:0] sum;
        sum     = SUM_W'(score_q) + SUM_W'(points);
        score_d = score_q;
        if (kill_now) begin
            if (sum > SUM_W'(SCORE_MAX)) begin
                score_d = SCORE_MAX;
            end else begin
                score_d = sum[SCORE_W-1:0];
            end
        end
    end

    // A group clears only when a kill empties it; spawn-driven emptiness
    // never pulses because a spawning group's hits are suppressed.
    always_comb begin
        group_clear_d    = 3'b000;
        group_clear_d[0] = kill_now & fly_mask[hit_sel]    & ((alive_d & fly_mask)    == '0);
        group_clear_d[1] = kill_now & spider_mask[hit_sel] & ((alive_d & spider_mask) == '0);
        group_clear_d[2] = kill_now & mosq_mask[hit_sel]   & ((alive_d & mosq_mask)   == '0);
    end

    // State registers; all_clear samples the registered alive vector so it
    // trails enemy_alive_out by one cycle.
    always_ff @(posedge clk25 or negedge global_reset_n) begin
        if (!global_reset_n) begin
            alive_q       <= '0;
            kill_valid_q  <= 1'b0;
            kill_idx_q    <= 5'd0;
            kill_type_q   <= 2'd0;
            score_q       <= '0;
            group_clear_q <= 3'b000;
            all_clear_q   <= 1'b0;
        end else begin
            alive_q       <= alive_d;
            kill_valid_q  <= kill_valid_d;
            kill_idx_q    <= kill_idx_d;
            kill_type_q   <= kill_type_d;
            score_q       <= score_d;
            group_clear_q <= group_clear_d;
            all_clear_q   <= (alive_q == '0);
        end
    end

    assign bus.hit_ready       = hit_ready_w;
    assign bus.enemy_alive_out = alive_q;
    assign bus.kill_valid      = kill_valid_q;
    assign bus.kill_idx        = kill_idx_q;
    assign bus.kill_type       = kill_type_q;
    assign bus.score           = score_q;
    assign bus.group_clear     = group_clear_q;
    assign bus.all_clear       = all_clear_q;

endmodule

// File: tb/tb_enemy_hit_manager.sv
// Directed testbench for enemy_hit_manager. A second instance with a 6-bit
// score exercises saturation. Expectations adapt to ENEMY_HP_EN.
module tb_enemy_hit_manager;

`ifdef ENEMY_HP_EN
    localparam int SPIDER_HITS = 2;
    localparam int MOSQ_HITS   = 3;
`else
    localparam int SPIDER_HITS = 1;
    localparam int MOSQ_HITS   = 1;
`endif

    logic clk25 = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #20 clk25 = ~clk25;

    enemy_hit_manager_if #(.ENEMY_COUNT(23), .SCORE_W(16)) bus  ();
    enemy_hit_manager_if #(.ENEMY_COUNT(23), .SCORE_W(6))  bus6 ();

    enemy_hit_manager #(.SCORE_W(16)) dut (
        .clk25          (clk25),
        .global_reset_n (rst_n),
        .bus            (bus)
    );

    enemy_hit_manager #(.SCORE_W(6)) dut6 (
        .clk25          (clk25),
        .global_reset_n (rst_n),
        .bus            (bus6)
    );

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic hit(input logic [4:0] idx);
        bus.hit_valid = 1'b1;
        bus.hit_idx   = idx;
        tick();
        bus.hit_valid = 1'b0;
    endtask

    task automatic hit6(input logic [4:0] idx);
        bus6.hit_valid = 1'b1;
        bus6.hit_idx   = idx;
        tick();
        bus6.hit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.enemy_alive_out !== 23'h0 || bus.kill_valid !== 1'b0 || bus.score !== 16'd0 ||
            bus.group_clear !== 3'b000 || bus.all_clear !== 1'b0 || bus.hit_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: alive=%h kv=%b score=%0d gc=%b ac=%b hr=%b required all 0",
                     bus.enemy_alive_out, bus.kill_valid, bus.score, bus.group_clear,
                     bus.all_clear, bus.hit_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.hit_ready !== 1'b1 || bus.all_clear !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: hr=%b ac=%b required hr=1 ac=0", bus.hit_ready, bus.all_clear);
        end
        tick();
        checks++;
        if (bus.all_clear !== 1'b1) begin
            errors++;
            $display("FAIL reset_all_clear: got %b required 1", bus.all_clear);
        end
        $display("reset: alive=%h all_clear=%b", bus.enemy_alive_out, bus.all_clear);
    endtask

    task automatic test_fly_spawn();
        bus.enemy_alive_in = 23'h01FFFF;
        bus.reset_fly      = 1'b1;
        tick();
        bus.reset_fly = 1'b0;
        checks++;
        if (bus.enemy_alive_out !== 23'h01FFFF || bus.all_clear !== 1'b1) begin
            errors++;
            $display("FAIL fly_spawn: alive=%h ac=%b required alive=01ffff ac=1",
                     bus.enemy_alive_out, bus.all_clear);
        end
        tick();
        checks++;
        if (bus.all_clear !== 1'b0) begin
            errors++;
            $display("FAIL fly_all_clear_lag: got %b required 0", bus.all_clear);
        end
        $display("fly_spawn: alive=%h all_clear=%b", bus.enemy_alive_out, bus.all_clear);
    endtask

    task automatic test_spider_kill();
        bus.enemy_alive_in = 23'h7FFFFF;
        bus.reset_spider   = 1'b1;
        tick();
        bus.reset_spider = 1'b0;
        checks++;
        if (bus.enemy_alive_out !== 23'h1FFFFF) begin
            errors++;
            $display("FAIL spider_spawn: alive=%h required 1fffff", bus.enemy_alive_out);
        end
        for (int n = 1; n < SPIDER_HITS; n++) begin
            hit(5'd17);
            checks++;
            if (bus.enemy_alive_out !== 23'h1FFFFF || bus.kill_valid !== 1'b0 || bus.score !== 16'd0) begin
                errors++;
                $display("FAIL spider_first_hit: alive=%h kv=%b score=%0d required 1fffff 0 0",
                         bus.enemy_alive_out, bus.kill_valid, bus.score);
            end
        end
        hit(5'd17);
        checks++;
        if (bus.kill_valid !== 1'b1 || bus.kill_idx !== 5'd17 || bus.kill_type !== 2'd1 ||
            bus.score !== 16'd30 || bus.enemy_alive_out !== 23'h1DFFFF) begin
            errors++;
            $display("FAIL spider_kill: kv=%b idx=%0d type=%0d score=%0d alive=%h required 1 17 1 30 1dffff",
                     bus.kill_valid, bus.kill_idx, bus.kill_type, bus.score, bus.enemy_alive_out);
        end
        $display("spider_kill: idx=%0d type=%0d score=%0d", bus.kill_idx, bus.kill_type, bus.score);
        tick();
        checks++;
        if (bus.kill_valid !== 1'b0) begin
            errors++;
            $display("FAIL spider_kill_taken: kv=%b required 0", bus.kill_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.kill_ready = 1'b0;
        hit(5'd0);
        checks++;
        if (bus.kill_valid !== 1'b1 || bus.kill_idx !== 5'd0 || bus.kill_type !== 2'd0 ||
            bus.score !== 16'd40 || bus.hit_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_first_kill: kv=%b idx=%0d type=%0d score=%0d hr=%b required 1 0 0 40 0",
                     bus.kill_valid, bus.kill_idx, bus.kill_type, bus.score, bus.hit_ready);
        end
        bus.hit_valid = 1'b1;
        bus.hit_idx   = 5'd1;
        tick();
        tick();
        checks++;
        if (bus.kill_valid !== 1'b1 || bus.kill_idx !== 5'd0 || bus.score !== 16'd40 ||
            bus.enemy_alive_out !== 23'h1DFFFE || bus.hit_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: kv=%b idx=%0d score=%0d alive=%h hr=%b required 1 0 40 1dfffe 0",
                     bus.kill_valid, bus.kill_idx, bus.score, bus.enemy_alive_out, bus.hit_ready);
        end
        bus.kill_ready = 1'b1;
        #1;
        checks++;
        if (bus.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb: hr=%b required 1", bus.hit_ready);
        end
        tick();
        bus.hit_valid = 1'b0;
        checks++;
        if (bus.kill_valid !== 1'b1 || bus.kill_idx !== 5'd1 || bus.score !== 16'd50 ||
            bus.enemy_alive_out !== 23'h1DFFFC) begin
            errors++;
            $display("FAIL bp_second_kill: kv=%b idx=%0d score=%0d alive=%h required 1 1 50 1dfffc",
                     bus.kill_valid, bus.kill_idx, bus.score, bus.enemy_alive_out);
        end
        $display("backpressure: idx=%0d score=%0d", bus.kill_idx, bus.score);
        tick();
        checks++;
        if (bus.kill_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: kv=%b required 0", bus.kill_valid);
        end
    endtask

    task automatic test_last_kill();
        int pulses;
        pulses = 0;
        bus.enemy_alive_in = 23'h7FFFFF;
        bus.reset_mosquito = 1'b1;
        tick();
        bus.reset_mosquito = 1'b0;
        checks++;
        if (bus.enemy_alive_out !== 23'h7DFFFC) begin
            errors++;
            $display("FAIL mosq_spawn: alive=%h required 7dfffc", bus.enemy_alive_out);
        end
        for (int n = 0; n < MOSQ_HITS; n++) begin
            hit(5'd21);
            if (bus.group_clear[2]) pulses++;
        end
        for (int n = 0; n < MOSQ_HITS; n++) begin
            hit(5'd22);
            if (bus.group_clear[2]) pulses++;
        end
        checks++;
        if (bus.group_clear !== 3'b100 || bus.score !== 16'd150 || bus.enemy_alive_out !== 23'h1DFFFC) begin
            errors++;
            $display("FAIL mosq_last_kill: gc=%b score=%0d alive=%h required 100 150 1dfffc",
                     bus.group_clear, bus.score, bus.enemy_alive_out);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            if (bus.group_clear[2]) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL mosq_pulse_count: got %0d required 1", pulses);
        end
        $display("last_kill: pulses=%0d score=%0d", pulses, bus.score);
    endtask

    task automatic test_collision_invalid();
        bus.enemy_alive_in = 23'h7FFFFF;
        bus.reset_spider   = 1'b1;
        bus.hit_valid      = 1'b1;
        bus.hit_idx        = 5'd18;
        tick();
        bus.reset_spider = 1'b0;
        bus.hit_valid    = 1'b0;
        checks++;
        if (bus.enemy_alive_out !== 23'h1FFFFC || bus.kill_valid !== 1'b0 || bus.score !== 16'd150) begin
            errors++;
            $display("FAIL collision_spawn_wins: alive=%h kv=%b score=%0d required 1ffffc 0 150",
                     bus.enemy_alive_out, bus.kill_valid, bus.score);
        end
        for (int n = 1; n < SPIDER_HITS; n++) begin
            hit(5'd18);
            checks++;
            if (bus.enemy_alive_out !== 23'h1FFFFC || bus.kill_valid !== 1'b0) begin
                errors++;
                $display("FAIL collision_hp_full: alive=%h kv=%b required 1ffffc 0",
                         bus.enemy_alive_out, bus.kill_valid);
            end
        end
        hit(5'd18);
        checks++;
        if (bus.kill_valid !== 1'b1 || bus.kill_idx !== 5'd18 || bus.score !== 16'd180 ||
            bus.enemy_alive_out !== 23'h1BFFFC) begin
            errors++;
            $display("FAIL collision_kill: kv=%b idx=%0d score=%0d alive=%h required 1 18 180 1bfffc",
                     bus.kill_valid, bus.kill_idx, bus.score, bus.enemy_alive_out);
        end
        tick();
        hit(5'd25);
        hit(5'd23);
        checks++;
        if (bus.enemy_alive_out !== 23'h1BFFFC || bus.kill_valid !== 1'b0 || bus.score !== 16'd180 ||
            bus.hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL invalid_hit: alive=%h kv=%b score=%0d hr=%b required 1bfffc 0 180 1",
                     bus.enemy_alive_out, bus.kill_valid, bus.score, bus.hit_ready);
        end
        bus.enemy_alive_in = 23'h0;
        bus.reset_spider   = 1'b1;
        tick();
        bus.reset_spider = 1'b0;
        tick();
        checks++;
        if (bus.enemy_alive_out !== 23'h01FFFC || bus.group_clear !== 3'b000) begin
            errors++;
            $display("FAIL zero_spawn: alive=%h gc=%b required 01fffc 000",
                     bus.enemy_alive_out, bus.group_clear);
        end
        $display("collision_invalid: alive=%h score=%0d", bus.enemy_alive_out, bus.score);
    endtask

    task automatic test_back_to_back();
        bus.kill_ready = 1'b1;
        bus.hit_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.hit_idx = 5'(2 + k);
            tick();
            checks++;
            if (bus.kill_valid !== 1'b1 || bus.kill_idx !== 5'(2 + k) || bus.score !== 16'(190 + 10 * k)) begin
                errors++;
                $display("FAIL b2b_kill%0d: kv=%b idx=%0d score=%0d required 1 %0d %0d",
                         k, bus.kill_valid, bus.kill_idx, bus.score, 2 + k, 190 + 10 * k);
            end
            $display("b2b: idx=%0d score=%0d", bus.kill_idx, bus.score);
        end
        bus.hit_valid = 1'b0;
        checks++;
        if (bus.enemy_alive_out !== 23'h01FFC0) begin
            errors++;
            $display("FAIL b2b_alive: alive=%h required 01ffc0", bus.enemy_alive_out);
        end
    endtask

    task automatic test_saturation();
        bus6.enemy_alive_in = 23'h7FFFFF;
        bus6.reset_fly      = 1'b1;
        bus6.reset_spider   = 1'b1;
        bus6.reset_mosquito = 1'b1;
        tick();
        bus6.reset_fly      = 1'b0;
        bus6.reset_spider   = 1'b0;
        bus6.reset_mosquito = 1'b0;
        for (int n = 0; n < MOSQ_HITS; n++) hit6(5'd21);
        checks++;
        if (bus6.score !== 6'd50) begin
            errors++;
            $display("FAIL sat_first: score=%0d required 50", bus6.score);
        end
        for (int n = 0; n < MOSQ_HITS; n++) hit6(5'd22);
        checks++;
        if (bus6.score !== 6'd63) begin
            errors++;
            $display("FAIL sat_clamp: score=%0d required 63", bus6.score);
        end
        for (int n = 0; n < SPIDER_HITS; n++) hit6(5'd17);
        checks++;
        if (bus6.score !== 6'd63 || bus6.kill_idx !== 5'd17) begin
            errors++;
            $display("FAIL sat_hold: score=%0d idx=%0d required 63 17", bus6.score, bus6.kill_idx);
        end
        $display("saturation: score=%0d", bus6.score);
    endtask

    task automatic test_mid_reset();
        bus.kill_ready = 1'b0;
        hit(5'd6);
        checks++;
        if (bus.kill_valid !== 1'b1 || bus.kill_idx !== 5'd6) begin
            errors++;
            $display("FAIL mid_reset_setup: kv=%b idx=%0d required 1 6", bus.kill_valid, bus.kill_idx);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.kill_valid !== 1'b0 || bus.kill_idx !== 5'd0 || bus.enemy_alive_out !== 23'h0 ||
            bus.score !== 16'd0 || bus.group_clear !== 3'b000 || bus.all_clear !== 1'b0 ||
            bus.hit_ready !== 1'b0 || bus6.score !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset: kv=%b idx=%0d alive=%h score=%0d gc=%b ac=%b hr=%b s6=%0d required all 0",
                     bus.kill_valid, bus.kill_idx, bus.enemy_alive_out, bus.score,
                     bus.group_clear, bus.all_clear, bus.hit_ready, bus6.score);
        end
        $display("mid_reset: kv=%b score=%0d", bus.kill_valid, bus.score);
        bus.kill_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.enemy_alive_in  = '0;
        bus.reset_fly       = 1'b0;
        bus.reset_spider    = 1'b0;
        bus.reset_mosquito  = 1'b0;
        bus.hit_valid       = 1'b0;
        bus.hit_idx         = 5'd0;
        bus.kill_ready      = 1'b1;
        bus6.enemy_alive_in = '0;
        bus6.reset_fly      = 1'b0;
        bus6.reset_spider   = 1'b0;
        bus6.reset_mosquito = 1'b0;
        bus6.hit_valid      = 1'b0;
        bus6.hit_idx        = 5'd0;
        bus6.kill_ready     = 1'b1;

        test_reset();
        test_fly_spawn();
        test_spider_kill();
        test_backpressure();
        test_last_kill();
        test_collision_invalid();
        test_back_to_back();
        test_saturation();
        test_mid_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
